// File: rtl/pipeline_control_sequencer_pkg.sv
// rtl/pipeline_control_sequencer_pkg.sv - shared state encodings and constants for the stall/flush sequencer
package pipeline_control_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } seq_state_e;

  // Instruction word loaded into IF/ID whenever p1_flush is asserted.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic mem_stall(input logic req, input logic ready);
    return req & ~ready;
  endfunction

endpackage

// File: rtl/pipeline_control_sequencer_if.sv
// rtl/pipeline_control_sequencer_if.sv - hazard requests in, pipeline-register enables/flushes out
interface pipeline_control_sequencer_if;

  logic hz_load_use;
  logic br_taken;
  logic dmem_req;
  logic dmem_ready;

  logic pc_write;
  logic p1_write;
  logic p1_flush;
  logic p2_bubble;
  logic p34_hold;

  // master = pipeline side raising requests; slave = the sequencer
  modport master (
    output hz_load_use, br_taken, dmem_req, dmem_ready,
    input  pc_write, p1_write, p1_flush, p2_bubble, p34_hold
  );

  modport slave (
    input  hz_load_use, br_taken, dmem_req, dmem_ready,
    output pc_write, p1_write, p1_flush, p2_bubble, p34_hold
  );

endinterface

// File: rtl/pipeline_control_sequencer_sat_counter.sv
// rtl/pipeline_control_sequencer_sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_control_sequencer.sv
// rtl/pipeline_control_sequencer.sv - prioritised stall/flush sequencer for the 2-slot VLIW pipeline
module pipeline_control_sequencer
  import pipeline_control_sequencer_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_control_sequencer_if.slave  bus,
  output logic [1:0]                   state_o,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output logic                         mem_err
);

  localparam logic [2:0] LU_RELOAD     = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  seq_state_e state;
  seq_state_e state_next;
  logic [2:0] lu_cnt;
  logic [2:0] lu_cnt_next;
  logic [7:0] to_cnt;
  logic [7:0] to_cnt_next;
  logic       err_set;
  logic       mem_wait;
  logic       do_mem_hold;
  logic       do_redirect;
  logic       do_lu_stall;
  logic       in_flush;
  logic       flush_inc;
  logic       stall_inc;

  assign mem_wait = mem_stall(bus.dmem_req, bus.dmem_ready);

  // Priority in every state: memory wait, then branch redirect, then load-use.
  always_comb begin
    state_next  = state;
    lu_cnt_next = lu_cnt;
    to_cnt_next = to_cnt;
    err_set     = 1'b0;
    do_mem_hold = 1'b0;
    do_redirect = 1'b0;
    do_lu_stall = 1'b0;
    in_flush    = 1'b0;
    if (rst_n) begin
      case (state)
        ST_RUN, ST_LU_STALL: begin
          if (mem_wait) begin
            do_mem_hold = 1'b1;
            state_next  = ST_MEM_WAIT;
            to_cnt_next = 8'd1;
          end else if (bus.br_taken) begin
            do_redirect = 1'b1;
            state_next  = ST_FLUSH;
          end else if (state == ST_LU_STALL) begin
            do_lu_stall = 1'b1;
            lu_cnt_next = lu_cnt - 3'd1;
            if (lu_cnt == 3'd1) begin
              state_next = ST_RUN;
            end
          end else if (bus.hz_load_use) begin
            do_lu_stall = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_next  = ST_LU_STALL;
              lu_cnt_next = LU_RELOAD;
            end
          end
        end
        ST_MEM_WAIT: begin
          // Branch and load-use requests are re-presented once the pipeline thaws.
          do_mem_hold = 1'b1;
          if (bus.dmem_ready) begin
            state_next = ST_RUN;
          end else if (to_cnt == TIMEOUT_LIMIT) begin
            err_set    = 1'b1;
            state_next = ST_RUN;
          end else begin
            to_cnt_next = to_cnt + 8'd1;
          end
        end
        ST_FLUSH: begin
          in_flush = 1'b1;
          if (mem_wait) begin
            do_mem_hold = 1'b1;
            state_next  = ST_MEM_WAIT;
            to_cnt_next = 8'd1;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  assign bus.pc_write  = ~(do_mem_hold | do_lu_stall);
  assign bus.p1_write  = ~(do_mem_hold | do_lu_stall);
  assign bus.p1_flush  = do_redirect | in_flush;
  assign bus.p2_bubble = do_redirect | do_lu_stall;
  assign bus.p34_hold  = do_mem_hold;

  assign flush_inc = do_redirect;
  assign stall_inc = rst_n & ~bus.pc_write;
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      lu_cnt  <= 3'd0;
      to_cnt  <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state  <= state_next;
      lu_cnt <= lu_cnt_next;
      to_cnt <= to_cnt_next;
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
